// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between the
// instruction-fetch and data requesters; one transaction in flight at a time.
module mem_arbiter #(
  parameter int LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_in,
  input  logic [15:0] i_addr_in,
  input  logic        d_req_in,
  input  logic        d_wr_in,
  input  logic [15:0] d_addr_in,
  input  logic [15:0] d_wdata_in,
  output logic        mem_en_out,
  output logic        mem_wr_out,
  output logic [15:0] mem_addr_out,
  output logic [15:0] mem_wdata_out,
  input  logic [15:0] mem_rdata_in,
  output logic        i_done_out,
  output logic        d_done_out,
  output logic [15:0] rdata_out,
  output logic        i_stall_out,
  output logic        d_stall_out,
  output logic [2:0]  state_dbg
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  // Handshake: a requester raises req and holds it (with stable address,
  // direction and data) until its one-cycle done pulse; it may keep req high
  // after done to start another transaction, granted from IDLE.

  logic [2:0] state;
  logic       own;    // 0 = instruction side, 1 = data side
  logic       pri_d;  // data side wins the next tie
  logic [3:0] cnt;
  logic       grant_d;

  assign grant_d     = d_req_in & (~i_req_in | pri_d);
  assign i_stall_out = i_req_in & ~i_done_out;
  assign d_stall_out = d_req_in & ~d_done_out;
  assign state_dbg   = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      own           <= 1'b0;
      pri_d         <= 1'b1;
      cnt           <= 4'd0;
      mem_en_out    <= 1'b0;
      mem_wr_out    <= 1'b0;
      mem_addr_out  <= 16'h0000;
      mem_wdata_out <= 16'h0000;
      rdata_out     <= 16'h0000;
      i_done_out    <= 1'b0;
      d_done_out    <= 1'b0;
    end else begin
      mem_en_out <= 1'b0;
      i_done_out <= 1'b0;
      d_done_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_req_in | d_req_in) begin
            own           <= grant_d;
            mem_wr_out    <= grant_d & d_wr_in;
            mem_addr_out  <= grant_d ? d_addr_in : i_addr_in;
            mem_wdata_out <= grant_d ? d_wdata_in : 16'h0000;
            mem_en_out    <= 1'b1;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= LAT_M1;
          state <= (LAT > 1) ? S_WAIT : S_CAPTURE;
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          // Read data is valid exactly LAT cycles after the issue cycle.
          if (!mem_wr_out) rdata_out <= mem_rdata_in;
          i_done_out <= ~own;
          d_done_out <= own;
          state      <= S_DONE;
        end
        S_DONE: begin
          pri_d <= ~own;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random requesters,
// checked every cycle against a transaction-level timing model and memory.
module tb_mem_arbiter;

  localparam int LAT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT (LAT=4) ----------------
  logic        i_req_in = 1'b0, d_req_in = 1'b0, d_wr_in = 1'b0;
  logic [15:0] i_addr_in = '0, d_addr_in = '0, d_wdata_in = '0;
  logic [15:0] mem_rdata_in;
  logic        mem_en_out, mem_wr_out, i_done_out, d_done_out, i_stall_out, d_stall_out;
  logic [15:0] mem_addr_out, mem_wdata_out, rdata_out;
  logic [2:0]  state_dbg;

  mem_arbiter #(.LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_req_in(i_req_in), .i_addr_in(i_addr_in),
    .d_req_in(d_req_in), .d_wr_in(d_wr_in), .d_addr_in(d_addr_in), .d_wdata_in(d_wdata_in),
    .mem_en_out(mem_en_out), .mem_wr_out(mem_wr_out), .mem_addr_out(mem_addr_out),
    .mem_wdata_out(mem_wdata_out), .mem_rdata_in(mem_rdata_in),
    .i_done_out(i_done_out), .d_done_out(d_done_out), .rdata_out(rdata_out),
    .i_stall_out(i_stall_out), .d_stall_out(d_stall_out), .state_dbg(state_dbg)
  );

  // ---------------- LAT=1 DUT ----------------
  logic        i1_req = 1'b0, d1_req = 1'b0, d1_wr = 1'b0;
  logic [15:0] i1_addr = '0, d1_addr = '0, d1_wdata = '0, m1_rdata = '0;
  logic        en1, wr1, i1_done, d1_done, i1_stall, d1_stall;
  logic [15:0] addr1, wdata1, rdata1;
  logic [2:0]  state1;

  mem_arbiter #(.LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .i_req_in(i1_req), .i_addr_in(i1_addr),
    .d_req_in(d1_req), .d_wr_in(d1_wr), .d_addr_in(d1_addr), .d_wdata_in(d1_wdata),
    .mem_en_out(en1), .mem_wr_out(wr1), .mem_addr_out(addr1),
    .mem_wdata_out(wdata1), .mem_rdata_in(m1_rdata),
    .i_done_out(i1_done), .d_done_out(d1_done), .rdata_out(rdata1),
    .i_stall_out(i1_stall), .d_stall_out(d1_stall), .state_dbg(state1)
  );

  // ---------------- check bookkeeping ----------------
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // ---------------- memory environment ----------------
  logic [15:0] mem [256];
  int          rd_cycle = -1;
  logic [7:0]  rd_addr = '0;

  // ---------------- reference model + scoreboard ----------------
  bit          busy = 1'b0;
  int          g = 0;             // grant cycle of the current transaction
  bit          m_own = 1'b0, m_wr = 1'b0, pri_d = 1'b1;
  logic [15:0] m_addr = '0, m_wdata = '0, exp_rdata = '0;
  logic [0:0]  exp_q[$];
  bit          i_seen = 1'b0, d_seen = 1'b0;

  always @(negedge clk) begin
    int  k;
    bit  e_en, e_id, e_dd;
    logic [0:0] exp_own;
    if (rst) begin
      rd_cycle = -1;
      chk("rst_mem_en", 32'(mem_en_out), 32'd0);
      chk("rst_mem_wr", 32'(mem_wr_out), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr_out), 32'd0);
      chk("rst_rdata", 32'(rdata_out), 32'd0);
      chk("rst_i_done", 32'(i_done_out), 32'd0);
      chk("rst_d_done", 32'(d_done_out), 32'd0);
      busy = 1'b0; pri_d = 1'b1; exp_rdata = '0;
      exp_q.delete();
      i_seen = 1'b0; d_seen = 1'b0;
    end else begin
      // memory: read data appears exactly LAT cycles after the issue cycle
      if (cyc == rd_cycle) mem_rdata_in = mem[rd_addr];
      else mem_rdata_in = 16'($urandom);
      if (mem_en_out) begin
        if (mem_wr_out) mem[mem_addr_out[7:0]] = mem_wdata_out;
        else begin rd_cycle = cyc + LAT; rd_addr = mem_addr_out[7:0]; end
      end
      // expected outputs for this cycle from the transaction timeline
      k    = cyc - g;
      e_en = busy && (k == 1);
      e_id = busy && (k == LAT + 2) && !m_own;
      e_dd = busy && (k == LAT + 2) && m_own;
      chk("mem_en", 32'(mem_en_out), 32'(e_en));
      chk("i_done", 32'(i_done_out), 32'(e_id));
      chk("d_done", 32'(d_done_out), 32'(e_dd));
      chk("rdata", 32'(rdata_out), 32'(exp_rdata));
      chk("i_stall", 32'(i_stall_out), 32'(i_req_in && !e_id));
      chk("d_stall", 32'(d_stall_out), 32'(d_req_in && !e_dd));
      if (e_en) begin
        chk("issue_addr", 32'(mem_addr_out), 32'(m_addr));
        chk("issue_wr", 32'(mem_wr_out), 32'(m_wr));
        if (m_wr) chk("issue_wdata", 32'(mem_wdata_out), 32'(m_wdata));
      end
      if (i_done_out || d_done_out) begin
        exp_own = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
        chk("sb_owner", 32'(d_done_out), 32'(exp_own));
      end
      i_seen = i_done_out;
      d_seen = d_done_out;
      // advance the model with this cycle's requests
      if (!busy) begin
        if (i_req_in || d_req_in) begin
          m_own   = d_req_in && (!i_req_in || pri_d);
          m_wr    = m_own && d_wr_in;
          m_addr  = m_own ? d_addr_in : i_addr_in;
          m_wdata = d_wdata_in;
          busy    = 1'b1;
          g       = cyc;
          exp_q.push_back(m_own);
        end
      end else begin
        if (k == LAT + 1 && !m_wr) exp_rdata = mem[m_addr[7:0]];
        if (k == LAT + 2) begin busy = 1'b0; pri_d = !m_own; end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit side, output int dc);
    dc = -1000;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (side ? d_done_out : i_done_out) begin dc = cyc; break; end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0, dc;
    bit saw_wait, saw_done;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8'h40] = 16'hBEEF;
    mem[8'h10] = 16'h5555;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // single I read
    step(); t0 = cyc;
    i_req_in = 1'b1; i_addr_in = 16'h0040;
    wait_done(1'b0, dc);
    chk("single_i_done_cycle", 32'(dc - t0), 32'(LAT + 2));
    chk("single_i_rdata", 32'(rdata_out), 32'h0000BEEF);
    step(); i_req_in = 1'b0;

    // simultaneous pair: data side holds the tie priority
    step(); t0 = cyc;
    i_req_in = 1'b1; i_addr_in = 16'h0010;
    d_req_in = 1'b1; d_wr_in = 1'b0; d_addr_in = 16'h0200;
    wait_done(1'b1, dc);
    chk("pair1_d_done_cycle", 32'(dc - t0), 32'(LAT + 2));
    step(); d_req_in = 1'b0;
    wait_done(1'b0, dc);
    chk("pair1_i_done_cycle", 32'(dc - t0), 32'(2 * LAT + 5));
    chk("pair1_i_rdata", 32'(rdata_out), 32'h00005555);
    step(); i_req_in = 1'b0;

    // D write leaves rdata untouched
    step(); t0 = cyc;
    d_req_in = 1'b1; d_wr_in = 1'b1; d_addr_in = 16'h0300; d_wdata_in = 16'h1234;
    wait_done(1'b1, dc);
    chk("d_write_done_cycle", 32'(dc - t0), 32'(LAT + 2));
    chk("d_write_rdata_held", 32'(rdata_out), 32'h00005555);
    chk("d_write_mem", 32'(mem[8'h00]), 32'h00001234);
    step(); d_req_in = 1'b0; d_wr_in = 1'b0;

    // second pair: data side was served last, so I wins
    step(); t0 = cyc;
    i_req_in = 1'b1; i_addr_in = 16'h0020;
    d_req_in = 1'b1; d_addr_in = 16'h0210;
    wait_done(1'b0, dc);
    chk("pair2_i_done_cycle", 32'(dc - t0), 32'(LAT + 2));
    step(); i_req_in = 1'b0;
    wait_done(1'b1, dc);
    chk("pair2_d_done_cycle", 32'(dc - t0), 32'(2 * LAT + 5));
    step(); d_req_in = 1'b0;

    // reset during WAIT aborts the transaction
    step(); t0 = cyc;
    i_req_in = 1'b1; i_addr_in = 16'h0044;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_mem_en", 32'(mem_en_out), 32'd0);
    chk("async_rst_addr", 32'(mem_addr_out), 32'd0);
    chk("async_rst_rdata", 32'(rdata_out), 32'd0);
    chk("async_rst_i_done", 32'(i_done_out), 32'd0);
    i_req_in = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    step(); t0 = cyc;
    i_req_in = 1'b1;
    wait_done(1'b0, dc);
    chk("rerequest_done_cycle", 32'(dc - t0), 32'(LAT + 2));
    step(); i_req_in = 1'b0;

    // data side held through two transactions with I pending: D, I, D
    step(); t0 = cyc;
    i_req_in = 1'b1; i_addr_in = 16'h0050;
    d_req_in = 1'b1; d_wr_in = 1'b0; d_addr_in = 16'h0250;
    wait_done(1'b1, dc);
    chk("b2b_d1_done_cycle", 32'(dc - t0), 32'(LAT + 2));
    wait_done(1'b0, dc);
    chk("b2b_i_done_cycle", 32'(dc - t0), 32'(2 * LAT + 5));
    step(); i_req_in = 1'b0;
    wait_done(1'b1, dc);
    chk("b2b_d2_done_cycle", 32'(dc - t0), 32'(3 * LAT + 8));
    step(); d_req_in = 1'b0;

    // LAT=1 build: done two cycles after issue, WAIT never visited
    m1_rdata = 16'hA5A5;
    step(); t0 = cyc;
    i1_req = 1'b1; i1_addr = 16'h0077;
    saw_wait = 1'b0; saw_done = 1'b0; dc = -1000;
    for (int n = 0; n < 10 && !saw_done; n++) begin
      @(negedge clk);
      if (state1 == 3'd2) saw_wait = 1'b1;
      if (en1) chk("lat1_issue_addr", 32'(addr1), 32'h0077);
      chk("lat1_wr", 32'(wr1), 32'd0);
      chk("lat1_d_done", 32'(d1_done), 32'd0);
      chk("lat1_d_stall", 32'(d1_stall), 32'd0);
      chk("lat1_i_stall", 32'(i1_stall), 32'(!i1_done));
      if (i1_done) begin saw_done = 1'b1; dc = cyc; end
    end
    chk("lat1_done_cycle", 32'(dc - t0), 32'd3);
    chk("lat1_no_wait", 32'(saw_wait), 32'd0);
    chk("lat1_rdata", 32'(rdata1), 32'h0000A5A5);
    step(); i1_req = 1'b0;

    // random requesters obeying the hold-until-done protocol
    for (int n = 0; n < 1500; n++) begin
      step();
      if (i_req_in) begin
        if (i_seen && $urandom_range(0, 1) == 0) i_req_in = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        i_req_in = 1'b1; i_addr_in = 16'($urandom);
      end
      if (d_req_in) begin
        if (d_seen && $urandom_range(0, 1) == 0) d_req_in = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        d_req_in = 1'b1; d_wr_in = 1'($urandom_range(0, 1));
        d_addr_in = 16'($urandom); d_wdata_in = 16'($urandom);
      end
    end
    for (int n = 0; n < 60 && (i_req_in || d_req_in); n++) begin
      step();
      if (i_seen) i_req_in = 1'b0;
      if (d_seen) d_req_in = 1'b0;
    end
    chk("drain_i_req", 32'(i_req_in), 32'd0);
    chk("drain_d_req", 32'(d_req_in), 32'd0);
    repeat (LAT + 4) step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
